// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// parity mode codes and the data-bit-count mapping.
package uart_pkg;

    // 3-bit state encoding for the transmitter FSM.
    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_START_ENC  = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PARITY_ENC = 3'd3;
    localparam logic [2:0] ST_STOP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC
    } tx_state_e;

    // Parity mode codes as presented on cfg_parity; 2'b11 is reserved and
    // behaves as no parity.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // cfg_dbits 00..11 selects 5..8 data bits.
    function automatic logic [3:0] dbits_to_nbits(input logic [1:0] cfg);
        return 4'd5 + {2'b00, cfg};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count. Read data is the entry at the
// read pointer (show-ahead), so a pop consumes the word visible this cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    // Guard both sides so a stray push when full or pop when empty is a no-op.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks
    // occupancy, unchanged when push and pop coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with a transmit FIFO and run-time frame format
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits). Bit timing comes
// from an external oversampling tick, OVS ticks per bit.
//
// Handshake: a word on din is transferred on every clock edge where
// din_valid && din_ready; din_ready is high whenever the FIFO has room and
// does not depend on din_valid. The producer holds din stable while
// din_valid is high and not yet accepted.
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int DBIT_MAX   = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_tick,
    input  logic [1:0]                   cfg_dbits,
    input  logic [1:0]                   cfg_parity,
    input  logic                         cfg_stop2,
    input  logic [DBIT_MAX-1:0]          din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic                         tx,
    output logic                         tx_busy,
    output logic                         tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int             TW         = $clog2(2 * OVS);
    localparam logic [TW-1:0]  TICK_LAST1 = TW'(OVS - 1);
    localparam logic [TW-1:0]  TICK_LAST2 = TW'(2 * OVS - 1);

    tx_state_e             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [2:0]            bit_q, bit_d;
    logic [DBIT_MAX-1:0]   shift_q, shift_d;
    logic [3:0]            nbits_q, nbits_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  avail_q;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DBIT_MAX-1:0]   fifo_rdata;
    logic                  word_avail;

    logic [3:0]            new_nbits;
    logic                  new_ones_par;
    logic                  new_par_en;
    logic                  new_par_bit;
    logic [TW-1:0]         stop_last;
    logic                  start_frame;

    assign din_ready    = !fifo_full;
    assign fifo_push    = din_valid && din_ready;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != ST_IDLE);
    assign tx_done_tick = done_q;

    uart_tx_fifo #(
        .WIDTH (DBIT_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (din),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // A freshly written word becomes eligible for transmission one cycle
    // after it lands in the FIFO; this fixes the push-to-start-bit latency
    // at two edges. Qualifying with !fifo_empty keeps it safe after a pop.
    assign word_avail = avail_q && !fifo_empty;

    // Frame parameters derived from the head-of-FIFO word and current cfg_*;
    // only captured when a frame starts. Bits above nbits are masked out.
    always_comb begin
        new_nbits    = dbits_to_nbits(cfg_dbits);
        new_ones_par = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (i < int'(new_nbits)) begin
                new_ones_par = new_ones_par ^ fifo_rdata[i];
            end
        end
        new_par_en  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        new_par_bit = new_ones_par ^ (cfg_parity == PAR_ODD);
    end

    assign stop_last = stop2_q ? TICK_LAST2 : TICK_LAST1;

    // Next-state, counters, shift register and the registered tx value.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        done_d      = 1'b0;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (word_avail) begin
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST1) begin
                        state_d = ST_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST1) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == 3'(nbits_q - 4'd1)) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST1) begin
                        state_d = ST_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_q == stop_last) begin
                        done_d = 1'b1;
                        tick_d = '0;
                        if (word_avail) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase

        // Entering START from IDLE or straight out of STOP: pop the word and
        // freeze the frame format for the whole frame.
        if (start_frame) begin
            state_d   = ST_START;
            tick_d    = '0;
            bit_d     = '0;
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            nbits_d   = new_nbits;
            par_en_d  = new_par_en;
            par_bit_d = new_par_bit;
            stop2_d   = cfg_stop2;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and drives tx high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            nbits_q   <= 4'd5;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            avail_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            nbits_q   <= nbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            avail_q   <= !fifo_empty;
        end
    end

endmodule
